jb_ce_timer: RTL and testbench
==============================

// Module: jb_ce_timer
// PURPOSE
// - Programmable interval timer downstream of the divided clock-enable generator.
// - Consumes its clk_en_div1/2/4/8/16 strobes and selects one rate.
// - Counts a programmed number of selected strobes.
// - Emits tick/done pulses in periodic or one-shot mode; consumed by sampling/pacing logic.
// PARAMETERS
// - CNT_W  16  width of period and count (period range 1..2^CNT_W-1)
// PORTS
// - clk           in   1      system clock, single clock domain
// - reset_n       in   1      asynchronous, active-low reset
// - clk_en_div1   in   1      enable strobe, every cycle
// - clk_en_div2   in   1      enable strobe, 1 of 2 cycles
// - clk_en_div4   in   1      enable strobe, 1 of 4 cycles
// - clk_en_div8   in   1      enable strobe, 1 of 8 cycles
// - clk_en_div16  in   1      enable strobe, 1 of 16 cycles
// - rate_sel      in   3      0..4 = div1..div16; 5..7 illegal
// - period        in   CNT_W  selected strobes per tick; 0 illegal
// - one_shot      in   1      1 = stop after first tick; 0 = periodic
// - start         in   1      1-cycle request; sampled only in IDLE
// - stop          in   1      1-cycle abort; honoured in any state
// - busy          out  1      high in RUN
// - tick          out  1      1-cycle pulse per completed period
// - done          out  1      1-cycle pulse at one-shot completion or stop-abort
// - cfg_err       out  1      1-cycle pulse when start rejected
// - count         out  CNT_W  current strobe count
// BEHAVIOUR
// - Reset: asynchronous on reset_n low; all outputs 0, state IDLE, latched config 0; deassertion takes effect on the next clk edge.
// - All outputs are registered. No combinational input-to-output path.
// - FSM states: IDLE, RUN, FIN.
//   - IDLE -> RUN: start=1, stop=0, period!=0, rate_sel<=4. Latch rate_sel, period and one_shot; count<=0.
//   - IDLE + start with illegal config: cfg_err=1 for the following cycle; stay IDLE.
//   - IDLE + start=1 and stop=1 together: stop wins; no run, no done, no cfg_err.
//   - RUN: sel_ce = strobe chosen by latched rate. On sel_ce, count<=count+1.
//   - RUN terminal: sel_ce with count==period_q-1 -> count<=0 and tick=1 next cycle.
//     - Periodic: stay RUN.
//     - One-shot: go FIN.
//   - RUN + stop: go FIN immediately. stop has priority over a terminal strobe in the same cycle (no tick).
//   - FIN: done=1 for exactly 1 cycle, busy=0, count<=0; then -> IDLE unconditionally.
//   - start in RUN or FIN is ignored (not queued).
// - Timing:
//   - busy rises 1 cycle after an accepted start.
//   - First tick appears 1 cycle after the period_q-th selected strobe.
//   - One-shot: done is asserted in the same cycle as the final tick.
// - Config inputs are ignored outside IDLE; changes during RUN have no effect.
// - Unselected strobes are ignored entirely.
// - Strobes held low (upstream in reset): count freezes; no timeout.
// - period=1 at div1, periodic: tick high every cycle from 2nd RUN cycle.
// - count wraps only via the terminal compare; overflow is impossible for legal period.
// STRUCTURE
// - Shared package jb_clk_pkg:
//   - typedef enum logic[1:0] {IDLE,RUN,FIN} ce_tmr_state_t
//   - typedef enum logic[2:0] {RATE_DIV1..RATE_DIV16} ce_rate_t
//   - localparam NUM_RATES=5
// - Sub-module jb_ce_mux: registered-free 5:1 strobe select from ce_rate_t.
//   - Illegal code selects none.
//   - Instanced once.
// - Top: FSM, counter, period/config latch, output registers.
// TESTING
// - Reset: assert reset_n=0 mid-RUN, count=7 -> all outputs 0 asynchronously; FSM IDLE after release; no tick.
// - Periodic: rate_sel=2 (div4), period=3, start -> tick every 12 cycles, first 1 cycle after 3rd div4 strobe; count 0,1,2,0.
// - One-shot: rate_sel=4 (div16), period=2, one_shot=1 -> single tick+done ~32 cycles after start, busy low next cycle, no further ticks.
// - Illegal config:
//   - period=0, start -> cfg_err pulse, busy stays 0.
//   - rate_sel=5 -> same.
// - Simultaneous events:
//   - stop on the terminal strobe cycle -> done=1, tick=0.
//   - start+stop in IDLE -> nothing.
//   - start during RUN -> ignored, period unchanged.
// - Config change: modify period/rate_sel during RUN -> tick spacing unchanged until the next start.

Source files
------------

// File: rtl/jb_clk_pkg.sv
// Shared types for the clock-enable timer block.
// State, rate encoding and rate legality check.
package jb_clk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } ce_tmr_state_t;

  typedef enum logic [2:0] {
    RATE_DIV1,
    RATE_DIV2,
    RATE_DIV4,
    RATE_DIV8,
    RATE_DIV16
  } ce_rate_t;

  localparam int NUM_RATES = 5;

  // Codes at or above NUM_RATES have no strobe behind them.
  function automatic logic rate_legal(
    input logic [2:0] r
  );
    return r < 3'(NUM_RATES);
  endfunction

endpackage

// File: rtl/jb_ce_timer_if.sv
// Strobe, config, control and status bundle
// between the timer and its user.
interface jb_ce_timer_if #(
  parameter int CNT_W = 16
);

  logic             clk_en_div1;
  logic             clk_en_div2;
  logic             clk_en_div4;
  logic             clk_en_div8;
  logic             clk_en_div16;
  logic [2:0]       rate_sel;
  logic [CNT_W-1:0] period;
  logic             one_shot;
  logic             start;
  logic             stop;
  logic             busy;
  logic             tick;
  logic             done;
  logic             cfg_err;
  logic [CNT_W-1:0] count;

  modport master (
    output clk_en_div1,
    output clk_en_div2,
    output clk_en_div4,
    output clk_en_div8,
    output clk_en_div16,
    output rate_sel,
    output period,
    output one_shot,
    output start,
    output stop,
    input  busy,
    input  tick,
    input  done,
    input  cfg_err,
    input  count
  );

  modport slave (
    input  clk_en_div1,
    input  clk_en_div2,
    input  clk_en_div4,
    input  clk_en_div8,
    input  clk_en_div16,
    input  rate_sel,
    input  period,
    input  one_shot,
    input  start,
    input  stop,
    output busy,
    output tick,
    output done,
    output cfg_err,
    output count
  );

endinterface

// File: rtl/jb_ce_mux.sv
// Combinational 5:1 strobe select.
// Unknown rate codes select no strobe.
module jb_ce_mux
  import jb_clk_pkg::*;
(
  input  logic [NUM_RATES-1:0] ce_i,
  input  ce_rate_t             rate_i,
  output logic                 sel_ce_o
);

  // Pick the strobe matching the latched rate.
  always_comb begin
    sel_ce_o = 1'b0;
    unique case (rate_i)
      RATE_DIV1:  sel_ce_o = ce_i[0];
      RATE_DIV2:  sel_ce_o = ce_i[1];
      RATE_DIV4:  sel_ce_o = ce_i[2];
      RATE_DIV8:  sel_ce_o = ce_i[3];
      RATE_DIV16: sel_ce_o = ce_i[4];
      default:    sel_ce_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/jb_ce_timer.sv
// Programmable interval timer counting selected
// clock-enable strobes; periodic or one-shot.
module jb_ce_timer
  import jb_clk_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         reset_n,
  jb_ce_timer_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ce_tmr_state_t    state_q;
  ce_rate_t         rate_q;
  logic [CNT_W-1:0] period_q;
  logic             one_shot_q;
  logic [CNT_W-1:0] count_q;
  logic             busy_q;
  logic             tick_q;
  logic             done_q;
  logic             cfg_err_q;

  logic [NUM_RATES-1:0] ce_vec;
  logic                 sel_ce;
  logic                 cfg_ok;
  logic                 term;
  logic [CNT_W-1:0]     count_d;

  assign ce_vec = {
    bus.clk_en_div16,
    bus.clk_en_div8,
    bus.clk_en_div4,
    bus.clk_en_div2,
    bus.clk_en_div1
  };

  jb_ce_mux u_mux (
    .ce_i     (ce_vec),
    .rate_i   (rate_q),
    .sel_ce_o (sel_ce)
  );

  // Config legality, terminal detect and next count.
  always_comb begin
    cfg_ok  = (bus.period != '0)
           && rate_legal(bus.rate_sel);
    term    = sel_ce
           && (count_q == period_q - ONE);
    count_d = count_q + ONE;
  end

  // Timer FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rate_q     <= RATE_DIV1;
      period_q   <= '0;
      one_shot_q <= 1'b0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            if (cfg_ok) begin
              state_q    <= RUN;
              rate_q     <= ce_rate_t'(bus.rate_sel);
              period_q   <= bus.period;
              one_shot_q <= bus.one_shot;
              count_q    <= '0;
              busy_q     <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            count_q <= '0;
          end else if (term) begin
            count_q <= '0;
            tick_q  <= 1'b1;
            if (one_shot_q) begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (sel_ce) begin
            count_q <= count_d;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.tick    = tick_q;
  assign bus.done    = done_q;
  assign bus.cfg_err = cfg_err_q;
  assign bus.count   = count_q;

endmodule

// File: tb/tb_jb_ce_timer.sv
// Directed bench for jb_ce_timer with a
// time-stamped expectation scoreboard.
module tb_jb_ce_timer;

  localparam int S_BUSY = 0;
  localparam int S_TICK = 1;
  localparam int S_DONE = 2;
  localparam int S_CERR = 3;
  localparam int S_CNT  = 4;

  typedef struct {
    int          at;
    string       tag;
    int          sig;
    logic [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic en = 1'b1;
  logic [3:0] div_cnt = 4'd0;
  int cyc = 0;
  int vectors = 0;
  int fails = 0;
  int s;
  exp_t sb[$];

  jb_ce_timer_if #(.CNT_W(16)) bus ();

  jb_ce_timer #(.CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en) div_cnt <= div_cnt + 4'd1;
  end

  assign bus.clk_en_div1  = en;
  assign bus.clk_en_div2  = en && (div_cnt[0] == 1'b0);
  assign bus.clk_en_div4  = en && (div_cnt[1:0] == 2'd0);
  assign bus.clk_en_div8  = en && (div_cnt[2:0] == 3'd0);
  assign bus.clk_en_div16 = en && (div_cnt == 4'd0);

  task automatic chk(input string tag,
                     input logic [15:0] o,
                     input logic [15:0] e);
    vectors++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [15:0] obs(input int sig);
    case (sig)
      S_BUSY:  obs = {15'd0, bus.busy};
      S_TICK:  obs = {15'd0, bus.tick};
      S_DONE:  obs = {15'd0, bus.done};
      S_CERR:  obs = {15'd0, bus.cfg_err};
      S_CNT:   obs = bus.count;
      default: obs = 'x;
    endcase
  endfunction

  task automatic push(input int dt, input string tag,
                      input int sig, input int v);
    exp_t e;
    e.at  = s + dt;
    e.tag = tag;
    e.sig = sig;
    e.val = 16'(v);
    sb.push_back(e);
  endtask

  task automatic go_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic sync0();
    for (int k = 0; k < 20 && div_cnt != 4'd0; k++)
      @(negedge clk);
    if (div_cnt != 4'd0) begin
      fails++;
      $error("FAIL sync: div_cnt %0d expected 0", div_cnt);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        chk(sb[i].tag, obs(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    bus.rate_sel = 3'd0;
    bus.period   = 16'd0;
    bus.one_shot = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {15'd0, bus.busy}, 16'd0);
    chk("rst_tick", {15'd0, bus.tick}, 16'd0);
    chk("rst_done", {15'd0, bus.done}, 16'd0);
    chk("rst_cerr", {15'd0, bus.cfg_err}, 16'd0);
    chk("rst_cnt", bus.count, 16'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // periodic div4, period 3
    sync0();
    bus.rate_sel = 3'd2;
    bus.period   = 16'd3;
    bus.start    = 1'b1;
    s = cyc;
    push(1,  "per_busy", S_BUSY, 1);
    push(4,  "per_c0",   S_CNT,  0);
    push(5,  "per_c1",   S_CNT,  1);
    push(9,  "per_c2",   S_CNT,  2);
    push(12, "per_c2b",  S_CNT,  2);
    push(12, "per_t12",  S_TICK, 0);
    push(13, "per_t13",  S_TICK, 1);
    push(13, "per_c13",  S_CNT,  0);
    push(14, "per_t14",  S_TICK, 0);
    push(24, "per_t24",  S_TICK, 0);
    push(25, "per_t25",  S_TICK, 1);
    push(37, "per_t37",  S_TICK, 1);
    push(41, "per_done", S_DONE, 1);
    push(41, "per_bsy0", S_BUSY, 0);
    @(negedge clk);
    bus.start = 1'b0;
    go_to(s + 40);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    go_to(s + 44);

    // one-shot div16, period 2
    sync0();
    bus.rate_sel = 3'd4;
    bus.period   = 16'd2;
    bus.one_shot = 1'b1;
    bus.start    = 1'b1;
    s = cyc;
    push(1,  "os_busy",  S_BUSY, 1);
    push(17, "os_c1",    S_CNT,  1);
    push(32, "os_bsy32", S_BUSY, 1);
    push(32, "os_t32",   S_TICK, 0);
    push(33, "os_t33",   S_TICK, 1);
    push(33, "os_d33",   S_DONE, 1);
    push(33, "os_b33",   S_BUSY, 0);
    push(34, "os_d34",   S_DONE, 0);
    push(34, "os_t34",   S_TICK, 0);
    push(50, "os_t50",   S_TICK, 0);
    push(50, "os_b50",   S_BUSY, 0);
    @(negedge clk);
    bus.start = 1'b0;
    go_to(s + 52);
    bus.one_shot = 1'b0;

    // illegal period 0
    bus.rate_sel = 3'd0;
    bus.period   = 16'd0;
    bus.start    = 1'b1;
    s = cyc;
    push(1, "p0_cerr",  S_CERR, 1);
    push(1, "p0_busy",  S_BUSY, 0);
    push(2, "p0_cerr2", S_CERR, 0);
    push(2, "p0_busy2", S_BUSY, 0);
    @(negedge clk);
    bus.start = 1'b0;
    go_to(s + 4);

    // illegal rate codes
    for (int r = 5; r <= 7; r++) begin
      bus.rate_sel = 3'(r);
      bus.period   = 16'd3;
      bus.start    = 1'b1;
      s = cyc;
      push(1, "rt_cerr",  S_CERR, 1);
      push(1, "rt_busy",  S_BUSY, 0);
      push(3, "rt_busy3", S_BUSY, 0);
      @(negedge clk);
      bus.start = 1'b0;
      go_to(s + 4);
    end

    // start and stop together in idle
    bus.rate_sel = 3'd0;
    bus.period   = 16'd3;
    bus.start    = 1'b1;
    bus.stop     = 1'b1;
    s = cyc;
    push(1, "ss_busy", S_BUSY, 0);
    push(1, "ss_cerr", S_CERR, 0);
    push(1, "ss_done", S_DONE, 0);
    push(3, "ss_bsy3", S_BUSY, 0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    go_to(s + 5);

    // stop on the terminal strobe
    bus.period = 16'd4;
    bus.start  = 1'b1;
    s = cyc;
    push(4, "st_c3",   S_CNT,  3);
    push(5, "st_done", S_DONE, 1);
    push(5, "st_tick", S_TICK, 0);
    push(5, "st_busy", S_BUSY, 0);
    push(6, "st_d6",   S_DONE, 0);
    push(6, "st_t6",   S_TICK, 0);
    @(negedge clk);
    bus.start = 1'b0;
    go_to(s + 4);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    go_to(s + 8);

    // config change and restart attempt during run
    bus.period = 16'd5;
    bus.start  = 1'b1;
    s = cyc;
    push(6,  "cc_t6",  S_TICK, 1);
    push(8,  "cc_t8",  S_TICK, 0);
    push(9,  "cc_t9",  S_TICK, 0);
    push(9,  "cc_c9",  S_CNT,  3);
    push(11, "cc_t11", S_TICK, 1);
    push(13, "cc_t13", S_TICK, 0);
    push(16, "cc_t16", S_TICK, 1);
    push(19, "cc_d19", S_DONE, 1);
    @(negedge clk);
    bus.start = 1'b0;
    go_to(s + 3);
    bus.period   = 16'd2;
    bus.rate_sel = 3'd4;
    go_to(s + 7);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    go_to(s + 18);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    go_to(s + 21);

    // strobes frozen mid-run
    bus.rate_sel = 3'd0;
    bus.period   = 16'd6;
    bus.start    = 1'b1;
    s = cyc;
    push(3,  "fz_c3",  S_CNT,  2);
    push(4,  "fz_c4",  S_CNT,  2);
    push(12, "fz_c12", S_CNT,  2);
    push(12, "fz_b12", S_BUSY, 1);
    push(16, "fz_t16", S_TICK, 0);
    push(17, "fz_t17", S_TICK, 1);
    push(17, "fz_c17", S_CNT,  0);
    @(negedge clk);
    bus.start = 1'b0;
    go_to(s + 3);
    en = 1'b0;
    go_to(s + 13);
    en = 1'b1;
    go_to(s + 18);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    go_to(s + 22);

    // async reset mid-run at count 7
    bus.period = 16'd20;
    bus.start  = 1'b1;
    s = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    go_to(s + 8);
    chk("ar_c7", bus.count, 16'd7);
    reset_n = 1'b0;
    #1;
    chk("ar_busy", {15'd0, bus.busy}, 16'd0);
    chk("ar_tick", {15'd0, bus.tick}, 16'd0);
    chk("ar_done", {15'd0, bus.done}, 16'd0);
    chk("ar_cerr", {15'd0, bus.cfg_err}, 16'd0);
    chk("ar_cnt", bus.count, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    s = cyc;
    push(1, "ar_b1", S_BUSY, 0);
    push(2, "ar_c2", S_CNT,  0);
    push(3, "ar_t3", S_TICK, 0);
    push(5, "ar_b5", S_BUSY, 0);
    go_to(s + 8);

    foreach (sb[i]) begin
      vectors++;
      fails++;
      $error("FAIL stale %s: at %0d now %0d", sb[i].tag, sb[i].at, cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
